// File: rtl/pc_seq_ctrl.sv
// Fetch/update sequencer for the 8-slot PC bank: fetches at pc_in, hands the word to execute,
// then converts the execute result into single-cycle bank pulses. Optional: PC_SEQ_MEM_TIMEOUT_EN.
module pc_seq_ctrl #(
  parameter int PC_W        = 9,
  parameter int INSTR_W     = 16,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       halt,
  input  logic [PC_W-1:0]            pc_in,
  output logic                       mem_req,
  output logic [PC_W-1:0]            mem_addr,
  input  logic                       mem_ack,
  input  logic [INSTR_W-1:0]         mem_rdata,
  output logic [INSTR_W-1:0]         instr,
  output logic                       instr_valid,
  input  logic                       exec_done,
  input  logic [1:0]                 exec_cmd,
  input  logic [PC_W-1:0]            exec_target,
  output logic                       pc_inc,
  output logic                       pc_ref_inc,
  output logic                       pc_ref_dec,
  output logic                       pc_load,
  output logic [PC_W-1:0]            pc_load_val,
  output logic [$clog2(DEPTH)-1:0]   depth,
  output logic                       busy,
  output logic                       fault,
  output logic [1:0]                 fault_code
);

  localparam int DW = $clog2(DEPTH);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH - 1);

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_CALL_OVF = 2'd1;
  localparam logic [1:0] FC_RET_UDF  = 2'd2;
  localparam logic [1:0] FC_MEM_TMO  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_UPDATE, S_LOAD, S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    CMD_NEXT = 2'd0, CMD_JMP = 2'd1, CMD_CALL = 2'd2, CMD_RET = 2'd3
  } cmd_t;

  state_t          state, state_nxt;
  logic [1:0]      code_nxt;
  cmd_t            cmd_q;
  logic [PC_W-1:0] target_q;
  logic            halt_pend;
  logic            timeout_hit;

`ifdef PC_SEQ_MEM_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] tmr;

  // Counter is zero on every WAIT entry because it is held clear outside WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (state == S_WAIT) begin
      tmr <= tmr + TW'(1);
    end else begin
      tmr <= '0;
    end
  end

  assign timeout_hit = (state == S_WAIT) && !mem_ack && (tmr == TW'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    code_nxt  = fault_code;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = (halt || halt_pend) ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (mem_ack) begin
          state_nxt = S_EXEC;
        end else if (timeout_hit) begin
          state_nxt = S_FAULT;
          code_nxt  = FC_MEM_TMO;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          state_nxt = S_UPDATE;
          // Depth guard is checked here so the bank never sees an out-of-range pointer move.
          if (cmd_t'(exec_cmd) == CMD_CALL && depth == DEPTH_MAX) begin
            state_nxt = S_FAULT;
            code_nxt  = FC_CALL_OVF;
          end else if (cmd_t'(exec_cmd) == CMD_RET && depth == '0) begin
            state_nxt = S_FAULT;
            code_nxt  = FC_RET_UDF;
          end
        end
      end
      S_UPDATE: state_nxt = (cmd_q == CMD_CALL) ? S_LOAD : S_FETCH;
      S_LOAD:   state_nxt = S_FETCH;
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pc_inc      = (state == S_UPDATE) && (cmd_q == CMD_NEXT || cmd_q == CMD_CALL);
    pc_ref_inc  = (state == S_UPDATE) && (cmd_q == CMD_CALL);
    pc_ref_dec  = (state == S_UPDATE) && (cmd_q == CMD_RET);
    pc_load     = ((state == S_UPDATE) && (cmd_q == CMD_JMP)) || (state == S_LOAD);
    pc_load_val = pc_load ? target_q : '0;
    mem_req     = (state == S_WAIT);
    instr_valid = (state == S_EXEC);
    busy        = (state != S_IDLE) && (state != S_FAULT);
    fault       = (state == S_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      fault_code <= FC_NONE;
      mem_addr   <= '0;
      instr      <= '0;
      cmd_q      <= CMD_NEXT;
      target_q   <= '0;
      depth      <= '0;
      halt_pend  <= 1'b0;
    end else begin
      state      <= state_nxt;
      fault_code <= code_nxt;
      if (state == S_FETCH) mem_addr <= pc_in;
      if (state == S_WAIT && mem_ack) instr <= mem_rdata;
      if (state == S_EXEC && exec_done) begin
        cmd_q    <= cmd_t'(exec_cmd);
        target_q <= exec_target;
      end
      // depth moves on the same edge as the bank pointer so it mirrors it exactly
      if (state == S_UPDATE) begin
        if (cmd_q == CMD_CALL)     depth <= depth + DW'(1);
        else if (cmd_q == CMD_RET) depth <= depth - DW'(1);
      end
      if (state == S_IDLE || state == S_FETCH) begin
        halt_pend <= 1'b0;
      end else if (halt && (state inside {S_WAIT, S_EXEC, S_UPDATE, S_LOAD})) begin
        halt_pend <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  a_ref_excl: assert property (@(posedge clk) disable iff (!rst_n) !(pc_ref_inc && pc_ref_dec));
  a_load_inc: assert property (@(posedge clk) disable iff (!rst_n) !(pc_load && pc_inc));
`endif

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
Fetch/update sequencer for the 8-slot PC bank (bank of PCs plus a slot pointer). Issues instruction fetches at the current PC, hands the instruction to execute, then applies the execute result (next, jump, call, return) to the bank as single-cycle control pulses. Tracks call depth itself so the bank is never driven past either end; raises a fault instead.

Parameters:
PC_W, 9, PC / memory address width
INSTR_W, 16, instruction word width
DEPTH, 8, number of PC slots (call levels incl. base); depth counter width = $clog2(DEPTH)
TIMEOUT_CYC, 64, mem_ack timeout in cycles (used only with optional feature)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE and begin fetching
halt  in  1  stop at next FETCH entry, return to IDLE
pc_in  in  PC_W  current bank output (bank pc_out)
mem_req  out  1  fetch request, held until mem_ack
mem_addr  out  PC_W  fetch address, registered copy of pc_in at request
mem_ack  in  1  fetch complete, mem_rdata valid this cycle
mem_rdata  in  INSTR_W  fetched instruction
instr  out  INSTR_W  latched instruction
instr_valid  out  1  high throughout EXEC
exec_done  in  1  execute finished; exec_cmd/exec_target valid this cycle
exec_cmd  in  2  0=NEXT 1=JMP 2=CALL 3=RET
exec_target  in  PC_W  target for JMP/CALL
pc_inc  out  1  bank: increment current slot (1-cycle pulse)
pc_ref_inc  out  1  bank: pointer +1 (pulse)
pc_ref_dec  out  1  bank: pointer -1 (pulse)
pc_load  out  1  bank: load current slot with pc_load_val (pulse)
pc_load_val  out  PC_W  load value
depth  out  $clog2(DEPTH)  current slot index mirror
busy  out  1  state != IDLE and != FAULT
fault  out  1  sticky until reset
fault_code  out  2  0=none 1=call overflow 2=ret underflow 3=mem timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; depth 0; instr 0; fault_code 0. Reset mid-fetch drops mem_req immediately, no pulse emitted.
- States: IDLE, FETCH, WAIT, EXEC, UPDATE, LOAD, FAULT.
- IDLE: start=1 -> FETCH. halt ignored.
- FETCH (1 cycle): if halt=1 -> IDLE; else mem_req<=1, mem_addr<=pc_in -> WAIT.
- WAIT: mem_req held high, mem_addr stable. mem_ack=1 -> instr<=mem_rdata, mem_req<=0, instr_valid<=1 -> EXEC. Minimum fetch-to-EXEC: 2 cycles after FETCH with immediate ack.
- EXEC: wait for exec_done. On exec_done capture cmd/target, instr_valid<=0:
  NEXT -> UPDATE with pc_inc pulse.
  JMP -> UPDATE with pc_load, pc_load_val=exec_target.
  CALL: depth==DEPTH-1 -> FAULT code 1, no pulses; else UPDATE with pc_inc+pc_ref_inc same cycle (return addr = pc+1 kept in caller slot), depth+1, then LOAD.
  RET: depth==0 -> FAULT code 2, no pulses; else UPDATE with pc_ref_dec, depth-1.
- UPDATE: pulses asserted exactly this one cycle; -> FETCH (or LOAD for CALL).
- LOAD (CALL only): pc_load=1, pc_load_val=captured target, into new slot -> FETCH.
- At most one of pc_ref_inc/pc_ref_dec ever high; pc_load never coincident with pc_inc.
- FAULT: fault=1, all pulses/mem_req 0, depth frozen; exit only by reset.
- halt during WAIT/EXEC/UPDATE/LOAD: noted, acted on at next FETCH entry (current instruction completes).
- exec_done outside EXEC ignored; mem_ack outside WAIT ignored.

Optional Feature:
PC_SEQ_MEM_TIMEOUT_EN: defined -> cycle counter runs in WAIT, cleared on entry; reaching TIMEOUT_CYC without mem_ack -> mem_req<=0, FAULT code 3. Undefined -> WAIT indefinitely; code 3 never produced; TIMEOUT_CYC unused.

Test Plan:
Reset, start, pc_in=0x010, ack after 3 cycles, exec NEXT -> mem_addr=0x010, instr latched, one pc_inc pulse, next fetch issued 1 cycle after UPDATE.
CALL target 0x120 at depth 0 -> UPDATE cycle pc_inc=pc_ref_inc=1, next cycle pc_load=1 val 0x120, depth=1.
7 nested CALLs then 8th CALL -> depth=7, FAULT code 1, no bank pulses on 8th; RET at depth 0 from fresh reset -> FAULT code 2.
JMP 0x1FF then RET after one CALL -> pc_load val 0x1FF; pc_ref_dec single pulse, depth back to 0.
halt asserted in EXEC -> instruction completes its UPDATE, then IDLE, busy=0, no mem_req; rst_n low mid-WAIT -> mem_req=0 same cycle.
With PC_SEQ_MEM_TIMEOUT_EN, TIMEOUT_CYC=4, no ack -> FAULT code 3 after 4 WAIT cycles; without macro -> still in WAIT after 100 cycles.
